// File: rtl/uart_word_loader.sv
// uart_word_loader: 8N1 UART receiver that packs every four accepted bytes into a
// little-endian 32-bit word and strobes it out with an auto-incrementing word address.
// Optional build macro UART_LOADER_TIMEOUT_EN: drop a partial word after TIMEOUT_CYCLES idle.
module uart_word_loader #(
  parameter int CLK_DIV        = 434,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        uart_in,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        wr,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  // Reject configurations the bit timing cannot support.
  if (CLK_DIV < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_word_loader: CLK_DIV must be >= 4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic            rx_meta, rx_s, rx_prev;
  logic            fall;
  logic            shift_en, stop_ok, stop_bad;
  logic [7:0]      shreg;
  logic [1:0]      byte_cnt;
  logic            wr_q, ferr_q;
  logic            timeout;

  assign fall      = rx_prev & ~rx_s;
  assign busy      = (state != IDLE);
  assign wr        = wr_q & enable;
  assign frame_err = ferr_q & enable;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // FSM state, bit-timing counter and bit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // Next-state logic and the per-frame sample strobes; enable low overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_cnt;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = START;
          bit_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          bit_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          stop_ok   = rx_s;
          stop_bad  = ~rx_s;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      shift_en  = 1'b0;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
    end
  end

  // Byte shifter, word assembly, address counter and the one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
      data     <= '0;
      addr     <= '0;
      wr_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (!enable) begin
      byte_cnt <= '0;
      addr     <= '0;
      wr_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
      wr_q   <= stop_ok && (byte_cnt == 2'd3);
      ferr_q <= stop_bad;
      if (wr_q) addr <= addr + 32'd1;
      if (stop_ok) begin
        data[{byte_cnt, 3'b000} +: 8] <= shreg;
        byte_cnt <= byte_cnt + 2'd1;
      end else if (timeout) begin
        byte_cnt <= '0;
      end
    end
  end

`ifdef UART_LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout = (state == IDLE) && (byte_cnt != 2'd0) && !fall &&
                   (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a partial word waits in IDLE; any start edge restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!enable || fall || state != IDLE || byte_cnt == 2'd0) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: table-driven frame scenarios, hand-written corner sequences
// and randomized frames checked against a byte-queue reference model.
// CLK_DIV=8, TIMEOUT_CYCLES=100; the timeout expectation follows UART_LOADER_TIMEOUT_EN.
module tb_uart_word_loader;

  localparam int CLK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        uart_in;
  logic [31:0] addr;
  logic [31:0] data;
  logic        wr;
  logic        frame_err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] obs_post[$];
  int          ferr_cnt = 0;
  int          dbl_wr   = 0;
  bit          busy_seen = 1'b0;
  logic        wr_d = 1'b0;

  uart_word_loader #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .uart_in(uart_in),
    .addr(addr), .data(data), .wr(wr), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Observer on the falling edge, half a cycle away from the DUT's active edge.
  always @(negedge clk) begin
    if (wr_d) obs_post.push_back(addr);
    if (wr) begin
      obs_addr.push_back(addr);
      obs_data.push_back(data);
      if (wr_d) dbl_wr++;
    end
    if (frame_err) ferr_cnt++;
    if (busy) busy_seen = 1'b1;
    wr_d = wr;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive_bit(input logic v);
    uart_in = v;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  // One 8N1 frame; a bad stop bit is followed by one idle-high bit time.
  task automatic send_byte(input logic [7:0] b, input bit good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
    if (!good) drive_bit(1'b1);
    uart_in = 1'b1;
  endtask

  task automatic new_session();
    @(negedge clk);
    uart_in = 1'b1;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    obs_addr.delete();
    obs_data.delete();
    obs_post.delete();
    ferr_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic expect_writes(input string nm, input int n, input logic [31:0] d0,
                               input logic [31:0] d1, input int ferr);
    check({nm, " wr_count"}, 32'(obs_data.size()), 32'(n));
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      check({nm, " data"}, obs_data[i], (i == 0) ? d0 : d1);
      check({nm, " addr"}, obs_addr[i], 32'(i));
      if (i < obs_post.size()) check({nm, " addr_after"}, obs_post[i], 32'(i + 1));
    end
    check({nm, " frame_err_count"}, 32'(ferr_cnt), 32'(ferr));
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          n;
    logic [7:0]  bad_mask;
    int          exp_wr;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[5];

  logic [7:0]  pend[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] m_addr;
  int          m_ferr;

  initial begin
    vecs[0] = '{"lui_word",  64'h0000_0000_0010_0513, 4, 8'h00, 1, 32'h0010_0513, 32'h0, 0};
    vecs[1] = '{"b2b_8",     64'h0807_0605_0403_0201, 8, 8'h00, 2, 32'h0403_0201, 32'h0807_0605, 0};
    vecs[2] = '{"bad_first", 64'h0000_0044_3322_11AA, 5, 8'h01, 1, 32'h4433_2211, 32'h0, 1};
    vecs[3] = '{"partial3",  64'h0000_0000_00EE_FFC0, 3, 8'h00, 0, 32'h0, 32'h0, 0};
    vecs[4] = '{"two_bad",   64'h0000_0000_0000_5A5A, 2, 8'h03, 0, 32'h0, 32'h0, 2};

    // Reset state.
    rst = 1'b1; enable = 1'b0; uart_in = 1'b1;
    #1;
    check("reset addr", addr, 32'h0);
    check("reset data", data, 32'h0);
    check("reset wr", {31'b0, wr}, 32'h0);
    check("reset frame_err", {31'b0, frame_err}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table-driven frame scenarios, each from a fresh enable session.
    for (int v = 0; v < 5; v++) begin
      new_session();
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].bytes[8*i +: 8], !vecs[v].bad_mask[i]);
      repeat (8) @(negedge clk);
      expect_writes(vecs[v].name, vecs[v].exp_wr, vecs[v].exp_d0, vecs[v].exp_d1,
                    vecs[v].exp_ferr);
    end

    // Two-cycle low glitch while idle: START entered, then straight back to IDLE.
    new_session();
    uart_in = 1'b0;
    repeat (2) @(negedge clk);
    uart_in = 1'b1;
    repeat (CLK_DIV/2 + 5) @(negedge clk);
    check("glitch busy_seen", {31'b0, busy_seen}, 32'h1);
    check("glitch busy_low", {31'b0, busy}, 32'h0);
    expect_writes("glitch", 0, 32'h0, 32'h0, 0);

    // enable dropped in the middle of the third frame, then a fresh word.
    new_session();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("drop no_wr_before", 32'(obs_data.size()), 32'h0);
    enable  = 1'b0;
    uart_in = 1'b1;
    @(negedge clk);
    check("drop busy", {31'b0, busy}, 32'h0);
    check("drop addr", addr, 32'h0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (8) @(negedge clk);
    expect_writes("reenable", 1, 32'hDEAD_BEEF, 32'h0, 0);

    // Partial word followed by a long idle gap.
    new_session();
    send_byte(8'hFF, 1'b1);
    repeat (150) @(negedge clk);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    repeat (8) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
    expect_writes("timeout", 1, 32'h0403_0201, 32'h0, 0);
`else
    expect_writes("no_timeout", 1, 32'h0302_01FF, 32'h0, 0);
`endif

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    uart_in = 1'b0;
    repeat (12) @(negedge clk);
    check("midframe busy", {31'b0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst busy", {31'b0, busy}, 32'h0);
    check("arst data", data, 32'h0);
    check("arst addr", addr, 32'h0);
    @(negedge clk);
    uart_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Randomized frames against a byte-queue model of the loader.
    new_session();
    pend.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    m_addr = 0;
    m_ferr = 0;
    for (int f = 0; f < 48; f++) begin
      logic [7:0] b;
      bit good;
      b    = 8'($urandom);
      good = ($urandom_range(7) != 0);
      send_byte(b, good);
      if (good) begin
        pend.push_back(b);
        if (pend.size() == 4) begin
          exp_addr_q.push_back(m_addr);
          exp_data_q.push_back({pend[3], pend[2], pend[1], pend[0]});
          m_addr++;
          pend.delete();
        end
      end else begin
        m_ferr++;
      end
      repeat ($urandom_range(12)) @(negedge clk);
      if ($urandom_range(9) == 0) begin
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        pend.delete();
        m_addr = 0;
      end
    end
    repeat (8) @(negedge clk);
    check("rand wr_count", 32'(obs_data.size()), 32'(exp_data_q.size()));
    for (int i = 0; i < exp_data_q.size() && i < obs_data.size(); i++) begin
      check("rand data", obs_data[i], exp_data_q[i]);
      check("rand addr", obs_addr[i], exp_addr_q[i]);
    end
    check("rand frame_err_count", 32'(ferr_cnt), 32'(m_ferr));
    check("wr never back_to_back", 32'(dbl_wr), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Serial boot-loader front end: receives 8N1 UART bytes on `uart_in`, assembles every four accepted bytes into a little-endian 32-bit word and issues a one-cycle write strobe with an auto-incrementing word address. It sits directly upstream of the instruction ROM write port. While loading is enabled, the core is held in reset and `addr`/`data`/`wr` drive the ROM's address, write data and write enable.

## Interface

Parameters:
- `CLK_DIV`, 434: `clk` cycles per UART bit (50 MHz / 115200). Minimum 4.
- `TIMEOUT_CYCLES`, 2_000_000: idle cycles before a partial word is dropped. Used only with `UART_LOADER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  load mode (already debounced); low holds the block idle and cleared.
- `uart_in`  in  1  raw RX line, asynchronous, idle high.
- `addr`  out  32  word index of the current or next word.
- `data`  out  32  assembled word.
- `wr`  out  1  one-cycle write strobe.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.
- `busy`  out  1  high while a frame is in progress (not in IDLE).

## Operation

- RX synchroniser: `uart_in` passes through 2 flip-flops, both reset to 1. All decisions use the synchronised value `rx_s`.
- FSM states:
  - IDLE: a falling edge of `rx_s` (previous 1, current 0) -> START, with the bit counter cleared.
  - START: after `CLK_DIV/2` cycles (integer division), sample `rx_s`.
    - 1 -> IDLE. This is a glitch; no error is flagged.
    - 0 -> DATA, with the bit counter cleared.
  - DATA: every `CLK_DIV` cycles, sample `rx_s` and shift it in LSB-first. After the 8th sample -> STOP.
  - STOP: after `CLK_DIV` cycles, sample `rx_s`.
    - 1 -> byte accepted.
    - 0 -> `frame_err` pulses, the byte is discarded and the byte count is unchanged.
    - Either way -> IDLE. The block returns to IDLE at mid-stop-bit, so back-to-back frames are received.
- Word assembly:
  - An accepted byte with count k (0..3) is written into `data[8k+7:8k]`; the count then increments.
  - When byte 3 is accepted, `wr` is high for the following cycle and the count wraps to 0.
  - `addr` increments by 1 on the cycle after `wr`. It wraps at 2^32 with no flag.
- `enable` low, at any time including mid-frame:
  - FSM forced to IDLE.
  - Byte count set to 0; `addr` set to 0.
  - `wr` and `frame_err` forced to 0.
  - `data` holds its value.
  - The partial word is lost.
  - Each new enable session therefore loads from address 0.

## Timing

- Reset values: `addr`=0, `data`=0, `wr`=0, `frame_err`=0, `busy`=0, FSM=IDLE, byte count=0, sync flops=1.
- The synchroniser adds 2 cycles of latency from the `uart_in` edge to FSM reaction.
- `wr` is asserted 1 cycle after the stop-bit sample of the 4th byte. During the `wr` cycle, `data` already holds the full word and `addr` holds that word's index. `addr` shows index+1 from the next cycle.
- `data` byte lanes update 1 cycle after each accepted stop sample and then hold.
- `frame_err` is asserted 1 cycle after the bad stop sample, for 1 cycle.
- `wr` is never asserted for two consecutive cycles. The minimum spacing between strobes is 4 frames.
- Simultaneous `enable` fall and `wr` generation: `enable` wins, and no strobe is issued.
- Asynchronous `rst` mid-frame returns everything to reset values immediately.

## Configuration

- `UART_LOADER_TIMEOUT_EN` defined:
  - An idle counter runs while the FSM is in IDLE and the byte count is nonzero.
  - It clears on any falling edge of `rx_s`.
  - On reaching `TIMEOUT_CYCLES`, the byte count is set to 0, the partial word is dropped and `addr` is unchanged. This resynchronises word framing after host-side byte loss.
- `UART_LOADER_TIMEOUT_EN` not defined: there is no counter, and a partial word is held indefinitely until completed or until `enable` falls.

## Test plan

- `CLK_DIV`=8, `enable`=1, send bytes 0x13, 0x05, 0x10, 0x00 -> exactly one `wr` pulse, with `data`=0x00100513, `addr`=0 during the strobe, then `addr`=1.
- Send 8 bytes 0x01..0x08 back-to-back with no idle time -> two strobes: `data`=0x04030201 at `addr` 0, then 0x08070605 at `addr` 1; `frame_err` never asserted.
- Send 0xAA with the stop bit driven low, then 4 valid bytes 0x11..0x44 -> one `frame_err` pulse, then one `wr` with `data`=0x44332211 (the bad byte is not counted).
- Drive a 2-cycle low glitch on `uart_in` while idle -> no state change after START, `busy` back to 0 within `CLK_DIV/2`+3 cycles, no `wr` or `frame_err`.
- Send 2 bytes, drop `enable` mid-3rd-frame, re-enable, send 0xEF, 0xBE, 0xAD, 0xDE -> no strobe before the drop; after re-enable one `wr` with `data`=0xDEADBEEF at `addr` 0.
- With `UART_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send 1 byte 0xFF, idle 150 cycles, send 0x01..0x04 -> one `wr` with `data`=0x04030201. Without the macro, the same stimulus gives `data`=0x030201FF.
